gate_identifier: RTL

//   Trainer-kit self-test engine: the on-chip counterpart of the A/B truth-table sweep.

---
 rtl/gate_identifier.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gate_identifier.sv
// gate_identifier: sweeps A/B through 00..11 into an external gate, samples its
// synchronized response twice per vector, and classifies the resulting truth table.
`default_nettype none

module gate_identifier #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       resp_in,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drive_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       match,
  output logic       unstable
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam logic [CW-1:0] C_RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_SAMP1 = 3'd2,
    S_SAMP2 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_sync;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_s1;
  logic [3:0]    r_tt;
  logic [2:0]    r_code;
  logic          r_match;
  logic          r_unstable;
  logic          w_rs;
  logic [3:0]    w_tt_new;
  logic [2:0]    w_class;

  function automatic logic [2:0] classify(input logic [3:0] tt);
    case (tt)
      4'b1000: classify = 3'd0;
      4'b1110: classify = 3'd1;
      4'b0101: classify = 3'd2;
      4'b0111: classify = 3'd3;
      4'b0001: classify = 3'd4;
      4'b0110: classify = 3'd5;
      4'b1001: classify = 3'd6;
      default: classify = 3'd7;
    endcase
  endfunction

  assign w_rs = r_sync[1];

  always_comb begin
    w_tt_new        = r_tt;
    w_tt_new[r_idx] = w_rs;
  end

  assign w_class = classify(w_tt_new);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_DRIVE;
      S_DRIVE: if (r_cnt == '0) w_next = S_SAMP1;
      S_SAMP1: w_next = S_SAMP2;
      S_SAMP2: w_next = (r_idx == 2'd3) ? S_DONE : S_DRIVE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sync     <= 2'b00;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_s1       <= 1'b0;
      r_tt       <= 4'd0;
      r_code     <= 3'd0;
      r_match    <= 1'b0;
      r_unstable <= 1'b0;
    end else if (ena) begin
      r_state <= w_next;
      r_sync  <= {r_sync[0], resp_in};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tt       <= 4'd0;
            r_code     <= 3'd0;
            r_match    <= 1'b0;
            r_unstable <= 1'b0;
            r_idx      <= 2'd0;
            r_cnt      <= C_RELOAD;
          end
        end
        S_DRIVE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_SAMP1: r_s1 <= w_rs;
        S_SAMP2: begin
          r_tt <= w_tt_new;
          if (w_rs != r_s1) r_unstable <= 1'b1;
          // Classify on the final sample so the code is already valid while done is high.
          if (r_idx == 2'd3) begin
            r_code  <= w_class;
            r_match <= (w_class != 3'd7);
          end else begin
            r_idx <= r_idx + 2'd1;
            r_cnt <= C_RELOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign drive_en    = (r_state == S_DRIVE) || (r_state == S_SAMP1) || (r_state == S_SAMP2);
  assign drv_a       = drive_en & r_idx[0];
  assign drv_b       = drive_en & r_idx[1];
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign truth_table = r_tt;
  assign gate_code   = r_code;
  assign match       = r_match;
  assign unstable    = r_unstable;

endmodule

`default_nettype wire
